// File: rtl/cache_pkg.sv
// Shared cache/memory types: line geometry, line type, responder states.
// Imported by the responder top and its line storage.
package cache_pkg;

   localparam int WORD_W      = 32;
   localparam int LINE_WORDS  = 8;
   localparam int LINE_W      = WORD_W * LINE_WORDS;
   localparam int OFFSET_BITS = 5;

   typedef logic [LINE_W-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

   // Line index of a byte address; upper address bits alias modulo depth.
   function automatic logic [31:0] line_index(
      input logic [31:0] addr,
      input int          idx_w
   );
      logic [31:0] mask;
      mask = (32'd1 << idx_w) - 32'd1;
      return (addr >> OFFSET_BITS) & mask;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line storage: synchronous write, registered read.
// Ports: CLK, RST (clears read register only), en, we, addr, wdata, rdata.
module line_ram
   import cache_pkg::*;
#(
   parameter int DEPTH_LINES = 256,
   parameter int ADDR_W      = $clog2(DEPTH_LINES)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  line_t             wdata,
   output line_t             rdata
);

   line_t mem [DEPTH_LINES];

   // Array has no reset: stored lines survive RST.
   always_ff @(posedge CLK) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register only updates on a read, so it holds across writes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model answering cache line fills/write-backs.
// Ports: CLK, RST, mem_req/we/addr/wdata in; mem_rdata, mem_resp, busy out.
module main_mem_responder
   import cache_pkg::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH_LINES = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  line_t       mem_wdata,
   output line_t       mem_rdata,
   output logic        mem_resp,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam int IDX_HI = OFFSET_BITS + IDX_W;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   resp_state_t state_q;
   resp_state_t state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        commit;

   logic             cap_we;
   logic [IDX_W-1:0] cap_idx;
   line_t            cap_wdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[31:IDX_HI],
                               mem_addr[OFFSET_BITS-1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_req) begin
               state_d = WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Inputs are sampled only at acceptance; later changes are ignored.
   always_ff @(posedge CLK) begin
      if (!RST && state_q == IDLE && mem_req) begin
         cap_we    <= mem_we;
         cap_idx   <= mem_addr[OFFSET_BITS +: IDX_W];
         cap_wdata <= mem_wdata;
      end
   end

   // A reset on the commit edge aborts the access.
   line_ram #(
      .DEPTH_LINES(DEPTH_LINES),
      .ADDR_W     (IDX_W)
   ) u_ram (
      .CLK  (CLK),
      .RST  (RST),
      .en   (commit && !RST),
      .we   (cap_we),
      .addr (cap_idx),
      .wdata(cap_wdata),
      .rdata(mem_rdata)
   );

   assign mem_resp = (state_q == RESP);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed sequences,
// a vector table and a randomized run against a line-array model.
module tb_main_mem_responder;
   import cache_pkg::*;

   localparam int LAT = 4;

   logic  CLK = 1'b0;
   logic  RST = 1'b1;
   logic  mem_req = 1'b0;
   logic  mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   line_t mem_wdata = '0;
   line_t mem_rdata;
   logic  mem_resp;
   logic  busy;

   main_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(256)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_resp (mem_resp),
      .busy     (busy)
   );

   always #5 CLK = ~CLK;

   int    n_pass = 0;
   int    n_tot = 0;
   line_t mdl [256];
   line_t last_rd;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      line_t       wdata;
      line_t       exp;
   } vec_t;
   vec_t tbl [6];

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 5) % 256);
   endfunction

   function automatic line_t rnd_line();
      line_t l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1;
      repeat (n) @(posedge CLK);
      #1 RST = 1'b0;
      last_rd = '0;
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_resp", 256'(mem_resp), 256'd0);
      chk("rst_rdata", mem_rdata, '0);
   endtask

   // Issue one access from an IDLE cycle; scramble inputs while busy.
   task automatic run(input bit we, input logic [31:0] a, input line_t wd,
                      output line_t rd);
      int rc;
      rc = -1;
      rd = '0;
      mem_req = 1'b1;
      mem_we = we;
      mem_addr = a;
      mem_wdata = wd;
      for (int c = 1; c <= 20 && rc < 0; c++) begin
         @(posedge CLK);
         #1;
         if (c == 1) begin
            mem_req = 1'b0;
            mem_we = 1'($urandom);
            mem_addr = $urandom;
            mem_wdata = rnd_line();
         end
         if (mem_resp) begin
            rc = c;
            rd = mem_rdata;
         end
      end
      chk("latency", 256'(rc), 256'(LAT + 1));
      @(posedge CLK);
      #1;
      chk("resp_width", 256'(mem_resp), 256'd0);
      chk("idle_busy", 256'(busy), 256'd0);
   endtask

   task automatic acc(input bit we, input logic [31:0] a, input line_t wd,
                      input string nm);
      line_t rd;
      run(we, a, wd, rd);
      if (we) begin
         mdl[idx_of(a)] = wd;
         chk({nm, "_hold"}, rd, last_rd);
      end else begin
         chk(nm, rd, mdl[idx_of(a)]);
         last_rd = mdl[idx_of(a)];
      end
   endtask

   initial begin
      line_t seq_l;
      do_reset(3);

      // Preload every line; stray address bits must not matter.
      for (int i = 0; i < 256; i++) begin
         logic [31:0] a;
         a = ($urandom << 13) | (i << 5) | ($urandom % 32);
         acc(1'b1, a, rnd_line(), "preload");
      end

      // Fill after a 2-cycle reset.
      do_reset(2);
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h0000_0040;
      for (int c = 1; c <= 7; c++) begin
         @(posedge CLK);
         #1;
         if (c == 1) mem_req = 1'b0;
         chk($sformatf("fill_busy_c%0d", c), 256'(busy),
             256'(c <= 5));
         chk($sformatf("fill_resp_c%0d", c), 256'(mem_resp),
             256'(c == 5));
         if (c == 5) chk("fill_rdata", mem_rdata, mdl[2]);
      end
      last_rd = mdl[2];

      // Address/we/wdata change while busy is ignored.
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h0000_0040;
      for (int c = 1; c <= 6; c++) begin
         @(posedge CLK);
         #1;
         if (c == 1) mem_req = 1'b0;
         if (c == 2) begin
            mem_addr = 32'h0000_0080;
            mem_we = 1'b1;
            mem_wdata = rnd_line();
         end
         chk($sformatf("chg_resp_c%0d", c), 256'(mem_resp),
             256'(c == 5));
         if (c == 5) chk("chg_rdata", mem_rdata, mdl[2]);
      end
      mem_we = 1'b0;
      acc(1'b0, 32'h0000_0080, '0, "chg_line4");

      // Reset during WAIT aborts a write to line 4.
      mem_req = 1'b1;
      mem_we = 1'b1;
      mem_addr = 32'h0000_0080;
      mem_wdata = ~mdl[4];
      for (int c = 1; c <= 10; c++) begin
         @(posedge CLK);
         #1;
         if (c == 1) mem_req = 1'b0;
         if (c == 3) RST = 1'b1;
         if (c == 4) RST = 1'b0;
         chk($sformatf("abort_resp_c%0d", c), 256'(mem_resp), 256'd0);
         if (c >= 4)
            chk($sformatf("abort_busy_c%0d", c), 256'(busy), 256'd0);
      end
      chk("abort_rdata_clr", mem_rdata, '0);
      last_rd = '0;
      acc(1'b0, 32'h0000_0080, '0, "abort_old");

      // Back-to-back reads with req held high.
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h0000_0040;
      for (int c = 1; c <= 19; c++) begin
         @(posedge CLK);
         #1;
         if (c == 5) mem_addr = 32'h0000_0060;
         if (c == 11) mem_addr = 32'h0000_00A0;
         if (c == 13) mem_req = 1'b0;
         chk($sformatf("b2b_resp_c%0d", c), 256'(mem_resp),
             256'(c == 5 || c == 11 || c == 17));
         if (c == 5) chk("b2b_rd0", mem_rdata, mdl[2]);
         if (c == 11) chk("b2b_rd1", mem_rdata, mdl[3]);
         if (c == 17) chk("b2b_rd2", mem_rdata, mdl[5]);
      end
      last_rd = mdl[5];

      // Vector table.
      for (int k = 0; k < 8; k++)
         seq_l[k*32 +: 32] = (k + 1) * 32'h1111_1111;
      tbl[0] = '{1'b1, 32'h0000_0100, seq_l, '0};
      tbl[1] = '{1'b0, 32'h0000_011C, '0, seq_l};
      tbl[2] = '{1'b1, 32'h0000_2020, ~seq_l, '0};
      tbl[3] = '{1'b0, 32'h0000_0020, '0, ~seq_l};
      tbl[4] = '{1'b1, 32'h0000_1FE0, {8{32'hA5A5_5A5A}}, '0};
      tbl[5] = '{1'b0, 32'hFFFF_FFE0, '0, {8{32'hA5A5_5A5A}}};
      for (int v = 0; v < 6; v++) begin
         line_t rd;
         line_t prev;
         prev = last_rd;
         run(tbl[v].we, tbl[v].addr, tbl[v].wdata, rd);
         if (tbl[v].we) begin
            chk($sformatf("tbl%0d_hold", v), rd, prev);
            mdl[idx_of(tbl[v].addr)] = tbl[v].wdata;
         end else begin
            chk($sformatf("tbl%0d_rd", v), rd, tbl[v].exp);
            last_rd = tbl[v].exp;
         end
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++)
         acc(1'($urandom), $urandom, rnd_line(), "rand");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- LATENCY, 4, WAIT cycles per access (legal range 1..15).
- DEPTH_LINES, 256, number of stored lines (power of 2).
REQ-002 One clock SHALL be used; reset SHALL be synchronous and active-high.
REQ-003 Ports SHALL be, one per line, as name, direction, width, meaning:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- mem_req  in  1  cache controller access request, held until mem_resp.
- mem_we  in  1  1 = line write-back (dirty eviction), 0 = line fill.
- mem_addr  in  32  byte address; bits [4:0] ignored.
- mem_wdata  in  256  write-back line, 8 x 32-bit words, word 0 in [31:0].
- mem_rdata  out  256  fill line, valid during mem_resp.
- mem_resp  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-005 In IDLE with mem_req=1, the block SHALL capture mem_we, mem_addr and mem_wdata at the edge, load cnt=LATENCY-1 and enter WAIT.
REQ-006 In WAIT, cnt SHALL decrement each cycle. At cnt==0 the next edge SHALL commit the access and enter RESP.
REQ-007 Commit on a write SHALL store the captured wdata at line index = captured addr[5 +: log2(DEPTH_LINES)]. Commit on a read SHALL load that line into mem_rdata.
REQ-008 Address bits above the index SHALL be ignored, so aliasing wraps modulo DEPTH_LINES.
REQ-009 In RESP, mem_resp SHALL be 1 for exactly one cycle, followed unconditionally by IDLE.
REQ-010 Latency SHALL be fixed: mem_resp is high in cycle N+LATENCY+1 when the request is accepted in cycle N.
REQ-011 mem_req, mem_we, mem_addr and mem_wdata changes in WAIT or RESP SHALL be ignored, since inputs are captured only at acceptance.
REQ-012 mem_req still high in the first IDLE cycle after RESP SHALL be accepted as a new request (back-to-back, no bubble beyond IDLE).
REQ-013 mem_rdata SHALL hold its value until the next read commit; write commits SHALL NOT alter it.
REQ-014 A read of a line in the same request stream as an earlier write SHALL return the written data, with no forwarding hazard because accesses are serialized.
REQ-015 busy SHALL equal (state != IDLE).

Reset
REQ-016 RST SHALL force state=IDLE, cnt=0, mem_resp=0, busy=0 and mem_rdata=0 on the next edge, with priority over all other activity.
REQ-017 RST asserted in WAIT before the commit edge SHALL abort the access: no line is written and no mem_resp is produced.
REQ-018 RST SHALL NOT clear stored line contents.

Structure
REQ-019 A shared package cache_pkg SHALL hold WORD_W=32, LINE_WORDS=8, LINE_W=256, OFFSET_BITS=5, the line_t typedef and the responder state enum.
REQ-020 Line storage SHALL be one sub-module, line_ram: single port, synchronous write, registered read, DEPTH_LINES x LINE_W.
REQ-021 Control SHALL remain in main_mem_responder.

Verification
REQ-022 Fill after reset:
- Stimulus: RST 2 cycles, then req=1, we=0, addr=0x0000_0040 in cycle 0.
- Required: mem_resp only in cycle 5, busy in cycles 1-5, rdata = line 2 preload.
REQ-023 Write-back then fill:
- Stimulus: write addr=0x0000_0100 with wdata words 0x11111111..0x88888888, then read addr=0x0000_011C.
- Required: rdata equals the written line.
REQ-024 Aliasing:
- Stimulus: write addr=0x0000_2020, then read addr=0x0000_0020.
- Required: same line returned (DEPTH_LINES=256).
REQ-025 Back-to-back:
- Stimulus: req held high across three requests.
- Required: mem_resp in cycles 5, 11 and 17, each exactly one cycle wide.
REQ-026 Input change while busy:
- Stimulus: addr changed to 0x0000_0080 in cycle 2 of a read of 0x0000_0040.
- Required: line 2 returned.
REQ-027 Reset abort:
- Stimulus: RST in cycle 3 of a write to line 4.
- Required: no mem_resp, and a later read of line 4 returns the old contents.
